// File: rtl/totient_seg_scanner_if.sv
// rtl/totient_seg_scanner_if.sv - sample/control/display bundle for the totient segment scanner
//
// Purpose: groups the sampling controls, the incoming segment pattern and the
// multiplexed display/status outputs of totient_seg_scanner.
// Signals:
//   sample_en  capture seg_in this cycle
//   clr        synchronous clear of history, sum, count, bad_pat
//   mode       0: show history, 1: show sum
//   seg_in     {A..G} from the generator, A = bit6
//   seg_out    {A..G} of the scanned digit
//   dig_en     one-hot digit enable, bit0 = rightmost
//   sum        saturating sum of valid samples
//   count      number of valid samples, wraps
//   bad_pat    sticky undecodable-pattern flag
// Modports: master drives the controls and seg_in, slave is the scanner.

interface totient_seg_scanner_if #(
  parameter int SUM_W = 8
);
  logic             sample_en;
  logic             clr;
  logic             mode;
  logic [6:0]       seg_in;
  logic [6:0]       seg_out;
  logic [3:0]       dig_en;
  logic [SUM_W-1:0] sum;
  logic [4:0]       count;
  logic             bad_pat;

  modport master (
    output sample_en, clr, mode, seg_in,
    input  seg_out, dig_en, sum, count, bad_pat
  );

  modport slave (
    input  sample_en, clr, mode, seg_in,
    output seg_out, dig_en, sum, count, bad_pat
  );
endinterface

// File: rtl/totient_seg_scanner.sv
// rtl/totient_seg_scanner.sv - decodes generator segments, keeps history/sum, scans a 4-digit display
//
// Purpose: samples a 7-segment pattern, decodes it to a hex value, keeps a
// 4-deep history and a saturating running sum, and multiplexes either view
// onto a 4-digit common-segment display.
// Ports:
//   CLK_LABEL  clock, all state on the rising edge
//   R          asynchronous active-low reset
//   bus        totient_seg_scanner_if.slave (controls in, display/status out)
// Parameters:
//   PRESCALE   cycles each digit stays lit (>= 2)
//   SUM_W      running-sum width, saturates at all-ones

module totient_seg_scanner #(
  parameter int PRESCALE = 1000,
  parameter int SUM_W    = 8
) (
  input  logic                  CLK_LABEL,
  input  logic                  R,
  totient_seg_scanner_if.slave  bus
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int PAD_W = (SUM_W > 16) ? SUM_W : 16;
  // Digits 0/1 always carry sum nibbles; 2/3 only when the sum is wide enough.
  localparam logic [3:0] SUM_DIG_MASK = {(SUM_W > 12), (SUM_W > 8), 2'b11};

  // Returns {valid, value}; unknown patterns come back with valid = 0.
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'h7E: return 5'h10;
      7'h30: return 5'h11;
      7'h6D: return 5'h12;
      7'h79: return 5'h13;
      7'h33: return 5'h14;
      7'h5B: return 5'h15;
      7'h5F: return 5'h16;
      7'h70: return 5'h17;
      7'h7F: return 5'h18;
      7'h7B: return 5'h19;
      7'h77: return 5'h1A;
      7'h1F: return 5'h1B;
      7'h4E: return 5'h1C;
      7'h3D: return 5'h1D;
      7'h4F: return 5'h1E;
      7'h47: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'h0: return 7'h7E;
      4'h1: return 7'h30;
      4'h2: return 7'h6D;
      4'h3: return 7'h79;
      4'h4: return 7'h33;
      4'h5: return 7'h5B;
      4'h6: return 7'h5F;
      4'h7: return 7'h70;
      4'h8: return 7'h7F;
      4'h9: return 7'h7B;
      4'hA: return 7'h77;
      4'hB: return 7'h1F;
      4'hC: return 7'h4E;
      4'hD: return 7'h3D;
      4'hE: return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

  logic [PS_W-1:0]  pre_q;
  logic [1:0]       idx_q;
  logic [3:0][3:0]  hist_q;
  logic [3:0]       hist_vld_q;
  logic [SUM_W-1:0] sum_q;
  logic [4:0]       count_q;
  logic             bad_q;
  logic [6:0]       seg_q;
  logic [3:0]       dig_q;

  logic [4:0]       dec;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_sat;
  logic [PAD_W-1:0] sum_pad;
  logic [3:0]       nib;
  logic [6:0]       seg_nxt;
  logic [3:0]       dig_nxt;

  assign dec     = seg_dec(bus.seg_in);
  // One spare bit catches the carry; any carry clamps to all-ones.
  assign sum_ext = {1'b0, sum_q} + (SUM_W+1)'(dec[3:0]);
  assign sum_sat = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
  assign sum_pad = PAD_W'(sum_q);
  assign nib     = sum_pad[{idx_q, 2'b00} +: 4];

  // Display drive is computed from the current index and state, then registered,
  // so updates and mode changes show up exactly one edge later.
  always_comb begin
    seg_nxt = 7'h00;
    dig_nxt = 4'b0001 << idx_q;
    if (!bus.mode) begin
      if (hist_vld_q[idx_q]) seg_nxt = seg_enc(hist_q[idx_q]);
    end else if (SUM_DIG_MASK[idx_q]) begin
      seg_nxt = seg_enc(nib);
    end
  end

  always_ff @(posedge CLK_LABEL or negedge R) begin
    if (!R) begin
      pre_q      <= '0;
      idx_q      <= 2'd0;
      hist_q     <= '0;
      hist_vld_q <= 4'b0000;
      sum_q      <= '0;
      count_q    <= 5'd0;
      bad_q      <= 1'b0;
      seg_q      <= 7'h00;
      dig_q      <= 4'b0001;
    end else begin
      // Scan timing runs free of clr so the display never stalls.
      if (pre_q == PS_W'(PRESCALE - 1)) begin
        pre_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        pre_q <= pre_q + PS_W'(1);
      end

      if (bus.clr) begin
        hist_q     <= '0;
        hist_vld_q <= 4'b0000;
        sum_q      <= '0;
        count_q    <= 5'd0;
        bad_q      <= 1'b0;
      end else if (bus.sample_en) begin
        if (dec[4]) begin
          hist_q     <= {hist_q[2:0], dec[3:0]};
          hist_vld_q <= {hist_vld_q[2:0], 1'b1};
          sum_q      <= sum_sat;
          count_q    <= count_q + 5'd1;
        end else begin
          bad_q <= 1'b1;
        end
      end

      seg_q <= seg_nxt;
      dig_q <= dig_nxt;
    end
  end

  assign bus.seg_out = seg_q;
  assign bus.dig_en  = dig_q;
  assign bus.sum     = sum_q;
  assign bus.count   = count_q;
  assign bus.bad_pat = bad_q;

endmodule
